// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the matrix keypad scanner.
//   key_event_t  - one press/release/repeat event as held in the output slot
//   code_w()     - width of a key index for a ROWS x COLS matrix
//   ROW_N_RESET  - active-low row strobe pattern after reset (row 0 driven)
package keypad_pkg;

    // Widest key index the event struct can carry (up to 256 keys).
    localparam int CODE_MAX_W = 8;
    localparam int ROWS_MAX   = 32;

    localparam logic [ROWS_MAX-1:0] ROW_N_RESET = {{(ROWS_MAX-1){1'b1}}, 1'b0};

    typedef struct packed {
        logic [CODE_MAX_W-1:0] code;
        logic                  press;
        logic                  is_repeat;
    } key_event_t;

    function automatic int code_w(input int rows, input int cols);
        return (rows * cols > 1) ? $clog2(rows * cols) : 1;
    endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// key_debounce_cell: debounced state and disagreement counter for one key.
//   Clock, Reset - clock and synchronous active-high reset
//   sample       - this key's row is being sampled this cycle
//   raw          - synchronized raw key value (1 = pressed)
//   commit       - arbiter grant: toggle the debounced state now
//   state        - debounced key state
//   cand         - key has seen DEB_SCANS consecutive disagreeing samples
import keypad_pkg::*;

module key_debounce_cell #(
    parameter int DEB_SCANS = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic sample,
    input  logic raw,
    input  logic commit,
    output logic state,
    output logic cand
);

    localparam int            CW   = (DEB_SCANS > 1) ? $clog2(DEB_SCANS) : 1;
    localparam logic [CW-1:0] CMAX = CW'(DEB_SCANS - 1);

    logic [CW-1:0] cnt;

    assign cand = sample && (raw != state) && (cnt == CMAX);

    // A candidate that is not granted keeps its counter saturated so it
    // retries on the next sample of this row.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= 1'b0;
            cnt   <= '0;
        end else if (sample) begin
            if (raw == state) begin
                cnt <= '0;
            end else if (cnt != CMAX) begin
                cnt <= cnt + 1'b1;
            end else if (commit) begin
                state <= ~state;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: row-strobed matrix keypad scanner with per-key debounce and
// a single-entry valid/ready event slot.
//   Clock, Reset - clock and synchronous active-high reset
//   row_n        - active-low row strobe, one row low at a time
//   col_n        - asynchronous active-low column sense
//   key_valid    - event slot holds an event
//   key_ready    - consumer accepts the event
//   key_code     - key index row*COLS+col
//   key_press    - 1 = press, 0 = release
//   key_repeat   - event is an auto-repeat
//   pressed      - debounced state of every key
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat of the last pressed key).
module keypad_scanner import keypad_pkg::*; #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int SCAN_DIV     = 25000,
    parameter int DEB_SCANS    = 4,
    parameter int REPEAT_DELAY = 32,
    parameter int REPEAT_RATE  = 8
) (
    input  logic                          Clock,
    input  logic                          Reset,
    output logic [ROWS-1:0]               row_n,
    input  logic [COLS-1:0]               col_n,
    output logic                          key_valid,
    input  logic                          key_ready,
    output logic [code_w(ROWS,COLS)-1:0]  key_code,
    output logic                          key_press,
    output logic                          key_repeat,
    output logic [ROWS*COLS-1:0]          pressed
);

    localparam int            NKEYS      = ROWS * COLS;
    localparam int            CW         = code_w(ROWS, COLS);
    localparam int            RW         = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int            SW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SW-1:0] DWELL_LOAD = SW'(SCAN_DIV - 1);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_t;

    // ---------------- column synchronizer ----------------
    logic [COLS-1:0] col_meta, col_sync;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    // ---------------- scan sequencer ----------------
    logic [RW-1:0]   row_idx, row_idx_d;
    logic [SW-1:0]   dwell, dwell_d;
    logic [ROWS-1:0] row_n_q, row_n_d;
    logic            sample;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            row_idx <= '0;
            dwell   <= DWELL_LOAD;
            row_n_q <= ROW_N_RESET[ROWS-1:0];
        end else begin
            row_idx <= row_idx_d;
            dwell   <= dwell_d;
            row_n_q <= row_n_d;
        end
    end

    always_comb begin
        row_idx_d = row_idx;
        dwell_d   = dwell - 1'b1;
        row_n_d   = row_n_q;
        if (dwell == '0) begin
            dwell_d   = DWELL_LOAD;
            row_idx_d = (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;
            row_n_d   = ~(ROWS'(1) << row_idx_d);
        end
    end

    always_comb begin
        sample = (dwell == '0);
        row_n  = row_n_q;
    end

    // ---------------- debounce array ----------------
    logic [NKEYS-1:0] cand, grant;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            key_debounce_cell #(.DEB_SCANS(DEB_SCANS)) u_cell (
                .Clock  (Clock),
                .Reset  (Reset),
                .sample (sample && (row_idx == RW'(r))),
                .raw    (~col_sync[c]),
                .commit (grant[r*COLS+c]),
                .state  (pressed[r*COLS+c]),
                .cand   (cand[r*COLS+c])
            );
        end
    end

    // ---------------- commit arbiter ----------------
    // Only the sampled row can raise candidates, so the lowest index is the
    // lowest column.
    slot_state_t   slot_q, slot_d;
    logic          slot_free;
    logic          commit;
    logic          found;
    logic [CW-1:0] win_code;
    logic          win_press;

    always_comb begin
        grant     = '0;
        found     = 1'b0;
        win_code  = '0;
        win_press = 1'b0;
        for (int unsigned k = 0; k < NKEYS; k++) begin
            if (cand[k] && !found) begin
                found     = 1'b1;
                grant[k]  = slot_free;
                win_code  = CW'(k);
                win_press = ~pressed[k];
            end
        end
        commit = found && slot_free;
    end

    // ---------------- auto-repeat ----------------
    logic          rep_fire;
    logic [CW-1:0] rep_key;

`ifdef KEYPAD_REPEAT_EN
    localparam int RCW = 16;

    logic           frame_end;
    logic           rep_active, rep_first, rep_due;
    logic [RCW-1:0] rep_cnt;

    always_comb begin
        frame_end = sample && (row_idx == LAST_ROW);
        rep_due   = (rep_cnt == (rep_first ? RCW'(REPEAT_DELAY - 1) : RCW'(REPEAT_RATE - 1)));
        rep_fire  = frame_end && rep_active && rep_due && slot_free && !commit;
    end

    // A skipped attempt still consumes its period so repeats never queue up.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rep_active <= 1'b0;
            rep_first  <= 1'b1;
            rep_cnt    <= '0;
            rep_key    <= '0;
        end else if (commit && win_press) begin
            rep_active <= 1'b1;
            rep_first  <= 1'b1;
            rep_cnt    <= '0;
            rep_key    <= win_code;
        end else begin
            if (commit && (win_code == rep_key)) begin
                rep_active <= 1'b0;
            end
            if (frame_end && rep_active) begin
                if (rep_due) begin
                    rep_cnt   <= '0;
                    rep_first <= 1'b0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end
        end
    end
`else
    assign rep_fire = 1'b0;
    assign rep_key  = '0;
`endif

    // ---------------- output slot ----------------
    key_event_t ev_q, ev_d;
    logic       load, accept;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            slot_q <= SLOT_EMPTY;
            ev_q   <= '0;
        end else begin
            slot_q <= slot_d;
            if (load) begin
                ev_q <= ev_d;
            end
        end
    end

    always_comb begin
        accept    = (slot_q == SLOT_FULL) && key_ready;
        slot_free = (slot_q == SLOT_EMPTY) || key_ready;
        load      = commit || rep_fire;
        slot_d    = slot_q;
        if (load) begin
            slot_d = SLOT_FULL;
        end else if (accept) begin
            slot_d = SLOT_EMPTY;
        end
        if (commit) begin
            ev_d = '{code: CODE_MAX_W'(win_code), press: win_press, is_repeat: 1'b0};
        end else begin
            ev_d = '{code: CODE_MAX_W'(rep_key), press: 1'b1, is_repeat: 1'b1};
        end
    end

    always_comb begin
        key_valid  = (slot_q == SLOT_FULL);
        key_code   = CW'(ev_q.code);
        key_press  = ev_q.press;
        key_repeat = ev_q.is_repeat;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

    localparam int ROWS      = 4;
    localparam int COLS      = 4;
    localparam int SCAN_DIV  = 4;
    localparam int DEB_SCANS = 3;
    localparam int FRAME     = ROWS * SCAN_DIV;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        key_valid;
    logic        key_ready;
    logic [3:0]  key_code;
    logic        key_press;
    logic        key_repeat;
    logic [15:0] pressed;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [15:0] keys;        // physical key matrix: 1 = held down
    bit          rnd_ready;
    bit          ignore_rpt;

    typedef struct {
        int code;
        bit press;
        bit rpt;
        int t;
    } ev_t;
    ev_t evq[$];

    keypad_scanner #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEB_SCANS(DEB_SCANS),
        .REPEAT_DELAY(2), .REPEAT_RATE(1)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .row_n      (row_n),
        .col_n      (col_n),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_code   (key_code),
        .key_press  (key_press),
        .key_repeat (key_repeat),
        .pressed    (pressed)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Keypad matrix: a held key pulls its column low while its row is driven.
    always_comb begin
        col_n = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!row_n[r] && keys[r*COLS+c]) col_n[c] = 1'b0;
    end

    // Records accepted events; checks the slot holds steady under backpressure.
    logic       prev_hold = 1'b0;
    logic [3:0] prev_code;
    logic       prev_press, prev_rpt;
    always @(negedge Clock) begin
        if (prev_hold) begin
            checks++;
            if (key_valid !== 1'b1 || key_code !== prev_code ||
                key_press !== prev_press || key_repeat !== prev_rpt) begin
                errors++;
                $display("FAIL hold_stable: got valid=%b code=%0d press=%b rpt=%b, required valid=1 code=%0d press=%b rpt=%b",
                         key_valid, key_code, key_press, key_repeat, prev_code, prev_press, prev_rpt);
            end
        end
        prev_hold  = (Reset === 1'b0) && (key_valid === 1'b1) && (key_ready === 1'b0);
        prev_code  = key_code;
        prev_press = key_press;
        prev_rpt   = key_repeat;
        if (Reset === 1'b0 && key_valid === 1'b1 && key_ready === 1'b1 &&
            !(ignore_rpt && key_repeat === 1'b1))
            evq.push_back('{code: int'(key_code), press: key_press, rpt: key_repeat, t: cyc});
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge Clock);
            #1;
            if (rnd_ready) key_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic test_reset();
        int n;
        Reset = 1'b1; key_ready = 1'b0; keys = '0;
        tick(2);
        checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL reset_row_n: got %b required 1110", row_n); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", key_valid); end
        checks++; if (pressed !== 16'h0) begin errors++; $display("FAIL reset_pressed: got %h required 0000", pressed); end
        Reset = 1'b0;
        tick(3);
        checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL dwell_row0: got %b required 1110", row_n); end
        tick(1);
        checks++; if (row_n !== 4'b1101) begin errors++; $display("FAIL dwell_row1: got %b required 1101", row_n); end
        // Leave a press pending in the slot, then reset over it.
        keys[0] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 4*FRAME) begin tick(); n++; end
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd0 || key_press !== 1'b1) begin
            errors++; $display("FAIL pending_event: got valid=%b code=%0d press=%b required valid=1 code=0 press=1", key_valid, key_code, key_press);
        end
        Reset = 1'b1;
        tick(2);
        checks++; if (row_n !== 4'b1110) begin errors++; $display("FAIL midreset_row_n: got %b required 1110", row_n); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b required 0", key_valid); end
        checks++; if (pressed !== 16'h0) begin errors++; $display("FAIL midreset_pressed: got %h required 0000", pressed); end
        keys = '0; Reset = 1'b0; key_ready = 1'b1;
        tick(6*FRAME);
        checks++; if (evq.size() != 0) begin errors++; $display("FAIL event_lost: got %0d events required 0", evq.size()); end
    endtask

    task automatic test_clean_press();
        int n;
        evq.delete(); key_ready = 1'b1; keys = '0;
        tick($urandom_range(0, 15));
        keys[6] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 60) begin tick(); n++; end
        checks++; if (n < 35 || n > 50) begin errors++; $display("FAIL press_latency: got %0d cycles required 35..50", n); end
        checks++;
        if (key_code !== 4'd6 || key_press !== 1'b1 || key_repeat !== 1'b0) begin
            errors++; $display("FAIL press_event: got code=%0d press=%b rpt=%b required code=6 press=1 rpt=0", key_code, key_press, key_repeat);
        end
        tick(1);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL press_pulse: got valid=%b required 0", key_valid); end
        checks++; if (pressed !== 16'h0040) begin errors++; $display("FAIL press_state: got %h required 0040", pressed); end
        evq.delete();
        keys[6] = 1'b0;
        n = 0;
        while (evq.size() == 0 && n < 4*FRAME) begin tick(); n++; end
        checks++;
        if (evq.size() == 0) begin
            errors++; $display("FAIL release_event: got no event required code=6 press=0");
        end else if (evq[0].code != 6 || evq[0].press != 1'b0 || evq[0].rpt != 1'b0) begin
            errors++; $display("FAIL release_event: got code=%0d press=%b rpt=%b required code=6 press=0 rpt=0", evq[0].code, evq[0].press, evq[0].rpt);
        end
        tick(1);
        checks++; if (pressed !== 16'h0) begin errors++; $display("FAIL release_state: got %h required 0000", pressed); end
    endtask

    task automatic test_bounce();
        evq.delete(); keys = '0; key_ready = 1'b1;
        for (int rep = 0; rep < 2; rep++) begin
            tick($urandom_range(0, 15));
            keys[9] = 1'b1;
            tick(2*FRAME);
            checks++; if (pressed !== 16'h0) begin errors++; $display("FAIL bounce_state: got %h required 0000", pressed); end
            keys[9] = 1'b0;
            tick(2*FRAME);
        end
        tick(2*FRAME);
        checks++; if (evq.size() != 0) begin errors++; $display("FAIL bounce_events: got %0d events required 0", evq.size()); end
        checks++; if (pressed !== 16'h0) begin errors++; $display("FAIL bounce_final: got %h required 0000", pressed); end
    endtask

    task automatic test_collision();
        int n;
        key_ready = 1'b1; keys = '0;
        for (int ph = 0; ph < 2; ph++) begin
            evq.delete();
            tick($urandom_range(0, 15));
            keys[4] = (ph == 0); keys[5] = (ph == 0);
            n = 0;
            while (evq.size() < 2 && n < 6*FRAME) begin tick(); n++; end
            tick(2*FRAME);
            checks++;
            if (evq.size() != 2) begin
                errors++; $display("FAIL collide_count: got %0d events required 2", evq.size());
            end else begin
                checks++;
                if (evq[0].code != 4 || evq[1].code != 5 || evq[0].press != (ph == 0) || evq[1].press != (ph == 0)) begin
                    errors++; $display("FAIL collide_order: got %0d/%b then %0d/%b required 4/%b then 5/%b",
                                       evq[0].code, evq[0].press, evq[1].code, evq[1].press, ph == 0, ph == 0);
                end
                checks++;
                if (evq[1].t - evq[0].t != FRAME) begin
                    errors++; $display("FAIL collide_gap: got %0d cycles required %0d", evq[1].t - evq[0].t, FRAME);
                end
            end
            checks++;
            if (pressed !== ((ph == 0) ? 16'h0030 : 16'h0000)) begin
                errors++; $display("FAIL collide_state: got %h required %h", pressed, (ph == 0) ? 16'h0030 : 16'h0000);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        evq.delete(); keys = '0; key_ready = 1'b0;
        tick($urandom_range(0, 15));
        keys[0] = 1'b1;
        n = 0;
        while (key_valid !== 1'b1 && n < 4*FRAME) begin tick(); n++; end
        keys[15] = 1'b1;
        tick(6*FRAME);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 4'd0 || key_press !== 1'b1) begin
            errors++; $display("FAIL bp_hold: got valid=%b code=%0d press=%b required valid=1 code=0 press=1", key_valid, key_code, key_press);
        end
        checks++; if (pressed !== 16'h0001) begin errors++; $display("FAIL bp_blocked: got %h required 0001", pressed); end
        key_ready = 1'b1;
        tick(3*FRAME);
        checks++;
        if (evq.size() != 2) begin
            errors++; $display("FAIL bp_count: got %0d events required 2", evq.size());
        end else begin
            checks++;
            if (evq[0].code != 0 || evq[0].press != 1'b1 || evq[1].code != 15 || evq[1].press != 1'b1) begin
                errors++; $display("FAIL bp_order: got %0d/%b then %0d/%b required 0/1 then 15/1", evq[0].code, evq[0].press, evq[1].code, evq[1].press);
            end
        end
        checks++; if (pressed !== 16'h8001) begin errors++; $display("FAIL bp_state: got %h required 8001", pressed); end
        keys = '0;
        tick(5*FRAME);
        checks++;
        if (evq.size() != 4) begin
            errors++; $display("FAIL bp_release_count: got %0d events required 4", evq.size());
        end else begin
            checks++;
            if (evq[2].press != 1'b0 || evq[3].press != 1'b0 ||
                !((evq[2].code == 0 && evq[3].code == 15) || (evq[2].code == 15 && evq[3].code == 0))) begin
                errors++; $display("FAIL bp_release: got %0d/%b and %0d/%b required 0/0 and 15/0", evq[2].code, evq[2].press, evq[3].code, evq[3].press);
            end
        end
    endtask

    task automatic test_random();
        int n, want;
        logic [15:0] tog, seen;
        rnd_ready = 1'b1;
        for (int it = 0; it < 10; it++) begin
            evq.delete();
            tog = '0;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) tog[$urandom_range(0, 15)] = 1'b1;
            want = $countones(tog);
            tick($urandom_range(0, 15));
            keys = keys ^ tog;
            n = 0;
            while ((evq.size() < want || pressed !== keys) && n < 40*FRAME) begin tick(); n++; end
            tick(2*FRAME);
            checks++;
            if (evq.size() != want) begin
                errors++; $display("FAIL rand_count: iter %0d got %0d events required %0d", it, evq.size(), want);
            end
            checks++;
            if (pressed !== keys) begin errors++; $display("FAIL rand_state: iter %0d got %h required %h", it, pressed, keys); end
            seen = '0;
            foreach (evq[i]) begin
                checks++;
                if (evq[i].code < 0 || evq[i].code > 15 || !tog[evq[i].code] || seen[evq[i].code] ||
                    evq[i].press != keys[evq[i].code] || evq[i].rpt != 1'b0) begin
                    errors++; $display("FAIL rand_event: iter %0d got code=%0d press=%b rpt=%b, required one of toggled %h with press=state",
                                       it, evq[i].code, evq[i].press, evq[i].rpt, tog);
                end else begin
                    seen[evq[i].code] = 1'b1;
                end
            end
        end
        rnd_ready = 1'b0;
        key_ready = 1'b1;
        keys = '0;
        tick(6*FRAME);
        evq.delete();
    endtask

`ifdef KEYPAD_REPEAT_EN
    task automatic test_repeat();
        int n, n1;
        ignore_rpt = 1'b0;
        evq.delete(); keys = '0; key_ready = 1'b1;
        tick($urandom_range(0, 15));
        keys[3] = 1'b1;
        tick(8*FRAME);
        checks++;
        if (evq.size() < 3) begin
            errors++; $display("FAIL rep_count: got %0d events required at least 3", evq.size());
        end else begin
            checks++;
            if (evq[0].code != 3 || evq[0].press != 1'b1 || evq[0].rpt != 1'b0) begin
                errors++; $display("FAIL rep_press: got %0d/%b/%b required 3/1/0", evq[0].code, evq[0].press, evq[0].rpt);
            end
            checks++;
            if (evq[1].t - evq[0].t != 2*FRAME - SCAN_DIV) begin
                errors++; $display("FAIL rep_delay: got %0d cycles required %0d", evq[1].t - evq[0].t, 2*FRAME - SCAN_DIV);
            end
            for (int i = 1; i < evq.size(); i++) begin
                checks++;
                if (evq[i].code != 3 || evq[i].press != 1'b1 || evq[i].rpt != 1'b1 ||
                    (i > 1 && evq[i].t - evq[i-1].t != FRAME)) begin
                    errors++; $display("FAIL rep_event: #%0d got %0d/%b/%b gap %0d required 3/1/1 gap %0d",
                                       i, evq[i].code, evq[i].press, evq[i].rpt, evq[i].t - evq[i-1].t, FRAME);
                end
            end
        end
        keys[3] = 1'b0;
        n = 0;
        while ((evq.size() == 0 || evq[$].press != 1'b0) && n < 6*FRAME) begin tick(); n++; end
        checks++;
        if (evq.size() == 0 || evq[$].code != 3 || evq[$].press != 1'b0 || evq[$].rpt != 1'b0) begin
            errors++; $display("FAIL rep_release: no release event for code 3 within bound");
        end
        n1 = evq.size();
        tick(4*FRAME);
        checks++; if (evq.size() != n1) begin errors++; $display("FAIL rep_after_release: got %0d extra events required 0", evq.size() - n1); end
        checks++; if (pressed !== 16'h0) begin errors++; $display("FAIL rep_state: got %h required 0000", pressed); end
        ignore_rpt = 1'b1;
    endtask
`else
    task automatic test_no_repeat();
        int n;
        evq.delete(); keys = '0; key_ready = 1'b1;
        tick($urandom_range(0, 15));
        keys[3] = 1'b1;
        tick(8*FRAME);
        checks++;
        if (evq.size() != 1 || evq[0].code != 3 || evq[0].press != 1'b1 || evq[0].rpt != 1'b0) begin
            errors++; $display("FAIL norep_hold: got %0d events required exactly one 3/1/0", evq.size());
        end
        keys[3] = 1'b0;
        n = 0;
        while (evq.size() < 2 && n < 6*FRAME) begin tick(); n++; end
        tick(2*FRAME);
        checks++;
        if (evq.size() != 2 || evq[1].code != 3 || evq[1].press != 1'b0 || evq[1].rpt != 1'b0) begin
            errors++; $display("FAIL norep_release: got %0d events required 2 ending with 3/0/0", evq.size());
        end
    endtask
`endif

    initial begin
        Reset = 1'b1; key_ready = 1'b0; keys = '0; rnd_ready = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        ignore_rpt = 1'b1;
`else
        ignore_rpt = 1'b0;
`endif
        test_reset();
        test_clean_press();
        test_bounce();
        test_collision();
        test_backpressure();
        test_random();
`ifdef KEYPAD_REPEAT_EN
        test_repeat();
`else
        test_no_repeat();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Matrix keypad controller for the calculator front end. It strobes the keypad rows one at a time, samples the columns, and debounces every key independently with scan-frame counters. It emits one press or release event at a time to the input decoder over a valid/ready handshake, and never loses an event under backpressure.

## Interface
- `ROWS`, default 4: number of keypad rows.
- `COLS`, default 4: number of keypad columns.
- `SCAN_DIV`, default 25000: clock cycles each row is driven. Must be ≥ 4.
- `DEB_SCANS`, default 4: number of consecutive disagreeing samples needed to flip a key's state. Must be ≥ 1.
- `REPEAT_DELAY`, default 32: frames a key is held before the first repeat. Used only with the repeat macro.
- `REPEAT_RATE`, default 8: frames between repeats. Used only with the repeat macro.
- `Clock` input, 1 bit: the single clock.
- `Reset` input, 1 bit: synchronous, active-high reset.
- `row_n` output, ROWS bits: active-low row strobe; exactly one bit is low.
- `col_n` input, COLS bits: asynchronous, active-low column sense; a key reads 0 when pressed.
- `key_valid` output, 1 bit: an event is held in the output register.
- `key_ready` input, 1 bit: the consumer accepts the event.
- `key_code` output, clog2(ROWS*COLS) bits: key index, equal to row*COLS + col.
- `key_press` output, 1 bit: 1 for a press event, 0 for a release event.
- `key_repeat` output, 1 bit: the event is an auto-repeat.
- `pressed` output, ROWS*COLS bits: current debounced state of every key.

## Operation
- **Column synchronizer**
  - `col_n` passes through a 2-flop synchronizer.
  - Both flops reset to all-1, which reads as all keys released.
- **Scan**
  - Row index `r` starts at 0; `row_n = ~(1<<r)`.
  - A dwell counter loads `SCAN_DIV-1` and counts down.
  - At count 0 (the "sample cycle"), the synchronized columns are sampled for row `r`.
  - On the sample cycle, `r` advances (wrapping from `ROWS-1` to 0) and the counter reloads.
  - A frame ends on the sample cycle of row `ROWS-1`.
- **Per-key debounce at the sample cycle**, with `raw = ~col_sync[j]` and debounced state `s[k]`:
  - If `raw == s[k]`: `c[k] <= 0`.
  - Else if `c[k] < DEB_SCANS-1`: `c[k] <= c[k]+1`.
  - Else (`c[k] == DEB_SCANS-1`) the key is a commit candidate.
- **Commit arbitration**
  - At most one commit per sample cycle, allowed only when the output slot is free: `!key_valid`, or `key_valid && key_ready` in the same cycle.
  - The lowest-column candidate wins: `s[k]` toggles, `c[k]` is cleared, and the slot loads `{code, press=s_new, repeat=0}`.
  - Losing or blocked candidates keep `c[k]` saturated at `DEB_SCANS-1` and retry on that row's next sample.
  - If a candidate's raw value reverts before it retries, its counter clears normally and no event is produced.
- **Handshake**
  - `key_valid` stays high and the slot contents stay stable until `key_valid && key_ready` is seen at a clock edge.
  - A new commit may load in the same cycle as an acceptance (back-to-back events).
  - `key_ready` while `key_valid` is low is ignored.
- `pressed` equals the vector `s`.
- **Reset values** (also applied on mid-operation reset; any pending event is discarded):
  - `row_n` = all ones except bit 0 low.
  - Dwell counter = `SCAN_DIV-1`.
  - All `s` and `c` = 0.
  - `key_valid`, `key_code`, `key_press`, `key_repeat` = 0.

## Timing
- `row_n` changes in the cycle after a sample cycle.
- Columns are sampled `SCAN_DIV-1` cycles after the row change, which covers the 2-cycle synchronizer plus settle time.
- The event appears on `key_valid` one cycle after its commit sample cycle.
- Latency from a clean press to `key_valid` is between `DEB_SCANS-1` and `DEB_SCANS` frames, plus one cycle, when the slot is free.
- Throughput is at most one event per sample cycle.

## Configuration
- Macro: `KEYPAD_REPEAT_EN`.
- **Defined**
  - The most recent key pressed is tracked as the repeat key.
  - While it stays pressed, a frame counter issues a repeat event `{code, press=1, repeat=1}`:
    - first after `REPEAT_DELAY` frames,
    - then every `REPEAT_RATE` frames.
  - The repeat key's release, or a new press, rearms the counter.
  - A repeat is attempted at the frame end. It is skipped, not queued, if a commit occurs in that cycle or the slot is busy.
- **Undefined**
  - No repeat logic is compiled in and `key_repeat` is tied to 0.
  - `REPEAT_*` parameters are ignored.

## Structure
- Package `keypad_pkg` holds:
  - event struct `key_event_t {code, press, repeat}`,
  - code width function `code_w(ROWS,COLS)`,
  - the reset row pattern constant.
- One sub-module, `key_debounce_cell`: per-key state, counter, and candidate flag, instantiated ROWS×COLS times.
- The scan FSM, arbiter, output slot, and repeat logic stay in the top level.

## Test plan
All scenarios use `ROWS=COLS=4`, `SCAN_DIV=4`, `DEB_SCANS=3`.
1. **Reset:** assert `Reset` for 2 cycles → `row_n=4'b1110`, `key_valid=0`, `pressed=0`. Reset again mid-scan with a pending event → the same values, and the event is lost.
2. **Clean press:** hold row 1 / col 2 pressed, `key_ready=1` → `key_valid` pulses with `code=6`, `press=1` within 3 frames, and `pressed[6]=1`. On release → `code=6`, `press=0`.
3. **Bounce:** press a key for 2 frames, release, then repeat the pattern → no event and `pressed` stays 0.
4. **Same-row collision:** keys 4 and 5 go down together → the code 4 event comes first, and the code 5 event follows one frame later.
5. **Backpressure:** with `key_ready=0`, press key 0 then key 15 → only code 0 is presented, held stable. Raise `key_ready` → code 15 follows; no event is lost or duplicated.
6. **Repeat** (`KEYPAD_REPEAT_EN`, `REPEAT_DELAY=2`, `REPEAT_RATE=1`): hold key 3 → one press event, then `repeat=1` events every frame. Release → a release event and no further repeats.
